// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } scan_state_e;

  // Bit positions on the segment bus.
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Hex glyphs, bits g..a; entry 0 sits in the low slice.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Host/pin-side bundle of the scan controller.
interface seven_seg_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned ADDR_W     = $clog2(NUM_DIGITS)
) ();

  logic                  enable;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [3:0]            wr_data;
  logic                  wr_dp;
  logic [7:0]            segment_out;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  frame_done;

  modport master (
    output enable, wr_en, wr_addr, wr_data, wr_dp,
    input  segment_out, digit_sel, frame_done
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data, wr_dp,
    output segment_out, digit_sel, frame_done
  );

endinterface

// File: rtl/seven_seg_decoder.sv
// Combinational hex-to-7-segment glyph lookup.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_glyph
);

  // Table lookup, no state.
  always_comb begin
    o_glyph = GLYPHS[i_value];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment scanner: register file, blank/drive FSM, registered pins.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 5000,
  parameter int unsigned BLANK_CYCLES = 250,
  parameter int unsigned ADDR_W       = $clog2(NUM_DIGITS)
) (
  input logic                i_clk,
  input logic                i_rst_n,
  seven_seg_scanner_if.slave bus
);

  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [3:0]            r_value [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_dp;
  scan_state_e           r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_sel;
  logic                  r_frame_done;

  logic                  w_wr_hit;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [3:0]            w_cur_value;
  logic                  w_cur_dp;
  logic [6:0]            w_glyph;
  logic [7:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_sel_next;
  logic [IDX_W-1:0]      w_idx_next;

  // Decode write strobe; out-of-range addresses are dropped.
  always_comb begin
    w_wr_hit = bus.wr_en && (32'(bus.wr_addr) < NUM_DIGITS);
    w_wr_idx = IDX_W'(bus.wr_addr);
  end

  // Host register file, writable in every state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_value[i] <= '0;
      r_dp <= '0;
    end else if (w_wr_hit) begin
      r_value[w_wr_idx] <= bus.wr_data;
      r_dp[w_wr_idx]    <= bus.wr_dp;
    end
  end

  // Forward a same-edge write to the driven digit so the glyph updates one edge early.
  always_comb begin
    w_cur_value = r_value[r_idx];
    w_cur_dp    = r_dp[r_idx];
    if (w_wr_hit && (w_wr_idx == r_idx)) begin
      w_cur_value = bus.wr_data;
      w_cur_dp    = bus.wr_dp;
    end
  end

  seven_seg_decoder u_decoder (
    .i_value (w_cur_value),
    .o_glyph (w_glyph)
  );

  // Next-cycle pin values for the digit at r_idx.
  always_comb begin
    w_seg_next                = '0;
    w_seg_next[SEG_G:SEG_A]   = w_glyph;
    w_seg_next[SEG_DP]        = w_cur_dp;
    w_sel_next                = {{(NUM_DIGITS - 1){1'b0}}, 1'b1} << r_idx;
    w_idx_next                = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
  end

  // Scan FSM with registered outputs; enable low parks everything in idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_seg        <= '0;
      r_sel        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (!bus.enable) begin
        r_state <= StIdle;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_seg   <= '0;
        r_sel   <= '0;
      end else begin
        case (r_state)
          StIdle: begin
            r_state <= StBlank;
            r_cnt   <= '0;
            r_seg   <= '0;
            r_sel   <= '0;
          end
          StBlank: begin
            if (r_cnt == BLANK_LAST) begin
              r_state <= StDrive;
              r_cnt   <= '0;
              r_seg   <= w_seg_next;
              r_sel   <= w_sel_next;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          StDrive: begin
            if (r_cnt == DWELL_LAST) begin
              r_state      <= StBlank;
              r_cnt        <= '0;
              r_seg        <= '0;
              r_sel        <= '0;
              r_idx        <= w_idx_next;
              r_frame_done <= (r_idx == IDX_LAST);
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_seg <= w_seg_next;
            end
          end
          default: begin
            r_state <= StIdle;
            r_seg   <= '0;
            r_sel   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.segment_out = r_seg;
  assign bus.digit_sel   = r_sel;
  assign bus.frame_done  = r_frame_done;

endmodule
